// File: rtl/fetch_pc_controller_if.sv
// Fetch-stage PC control bundle between the PC controller and the PC register / imem / hazard logic.
// master = controller side (drives PC update and fetch strobes), slave = surrounding pipeline.
interface fetch_pc_controller_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_cur;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            imem_ready;
  logic [XLEN-1:0] pc_next;
  logic            pc_write;
  logic            imem_req;
  logic            if_id_flush;
  logic            fetch_valid;
  logic            redirect_pending;

  modport master (
    input  pc_cur, stall, redirect_valid, redirect_target, imem_ready,
    output pc_next, pc_write, imem_req, if_id_flush, fetch_valid, redirect_pending
  );

  modport slave (
    output pc_cur, stall, redirect_valid, redirect_target, imem_ready,
    input  pc_next, pc_write, imem_req, if_id_flush, fetch_valid, redirect_pending
  );
endinterface

// File: rtl/fetch_pc_controller.sv
// Fetch PC sequencer: picks next PC among redirect / stall / sequential and raises IF/ID flush.
// Latency: PC updates on the edge after pc_write=1; a ready redirect lands one cycle later.
// Backpressure: while imem_ready=0 the PC is frozen; redirects seen meanwhile are parked (last wins).
module fetch_pc_controller #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     PC_STEP      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_pc_controller_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state;
  logic            pend_valid;
  logic [XLEN-1:0] pend_target;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] redir_tgt;

  assign seq_pc    = bus.pc_cur + XLEN'(PC_STEP);
  assign redir_tgt = {bus.redirect_target[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (bus.redirect_valid) begin
            if (!bus.imem_ready) begin
              pend_target <= redir_tgt;
              pend_valid  <= 1'b1;
              state       <= WAIT;
            end
          end else if (!bus.stall && !bus.imem_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_ready) begin
            pend_valid <= 1'b0;
            state      <= RUN;
          end else if (bus.redirect_valid) begin
            pend_target <= redir_tgt;
            pend_valid  <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  always_comb begin
    bus.pc_next          = seq_pc;
    bus.pc_write         = 1'b0;
    bus.imem_req         = 1'b0;
    bus.if_id_flush      = 1'b0;
    bus.fetch_valid      = 1'b0;
    bus.redirect_pending = pend_valid & ~rst;
    if (rst) begin
      bus.pc_next     = RESET_VECTOR;
      bus.if_id_flush = 1'b1;
    end else begin
      case (state)
        BOOT: bus.if_id_flush = 1'b1;
        RUN: begin
          bus.imem_req = 1'b1;
          if (bus.redirect_valid) begin
            // Redirect outranks stall; without imem_ready it is parked instead of written.
            bus.if_id_flush = 1'b1;
            if (bus.imem_ready) begin
              bus.pc_next  = redir_tgt;
              bus.pc_write = 1'b1;
            end
          end else if (!bus.stall && bus.imem_ready) begin
            bus.pc_write    = 1'b1;
            bus.fetch_valid = 1'b1;
          end
        end
        WAIT: begin
          bus.imem_req = 1'b1;
          if (!bus.imem_ready) begin
            bus.if_id_flush = bus.redirect_valid;
          end else if (bus.redirect_valid || pend_valid) begin
            bus.pc_next     = bus.redirect_valid ? redir_tgt : pend_target;
            bus.pc_write    = 1'b1;
            bus.if_id_flush = 1'b1;
          end else if (!bus.stall) begin
            bus.pc_write    = 1'b1;
            bus.fetch_valid = 1'b1;
          end
        end
        default: bus.if_id_flush = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_controller.sv
// Directed bench for fetch_pc_controller: boot, stall, redirect priority, wait+redirect, wrap, reset mid-wait.
module tb_fetch_pc_controller;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  fetch_pc_controller_if #(.XLEN(32)) bus ();

  fetch_pc_controller #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000),
    .PC_STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Checks all six outputs for one cycle after inputs settle.
  task automatic outs(input string tag, input logic [31:0] nxt, input logic wr, input logic req,
                      input logic fl, input logic fv, input logic pend);
    #1;
    chk({tag, ".pc_next"}, bus.pc_next, nxt);
    chk({tag, ".pc_write"}, {31'd0, bus.pc_write}, {31'd0, wr});
    chk({tag, ".imem_req"}, {31'd0, bus.imem_req}, {31'd0, req});
    chk({tag, ".flush"}, {31'd0, bus.if_id_flush}, {31'd0, fl});
    chk({tag, ".fetch_valid"}, {31'd0, bus.fetch_valid}, {31'd0, fv});
    chk({tag, ".pending"}, {31'd0, bus.redirect_pending}, {31'd0, pend});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst                 = 1'b1;
    bus.pc_cur          = 32'h0;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    bus.imem_ready      = 1'b1;

    // Reset held for three cycles
    tick();
    outs("rst", 32'h0, 0, 0, 1, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    // BOOT cycle, then sequential fetch
    outs("boot", 32'h4, 0, 0, 1, 0, 0);
    tick();
    bus.pc_cur = 32'h0;
    outs("seq0", 32'h4, 1, 1, 0, 1, 0);
    tick();
    bus.pc_cur = 32'h4;
    outs("seq1", 32'h8, 1, 1, 0, 1, 0);
    tick();
    bus.pc_cur = 32'h8;
    outs("seq2", 32'hC, 1, 1, 0, 1, 0);
    tick();

    // Load-use stall for two cycles
    bus.pc_cur = 32'h10;
    bus.stall  = 1'b1;
    outs("stall0", 32'h14, 0, 1, 0, 0, 0);
    tick();
    outs("stall1", 32'h14, 0, 1, 0, 0, 0);
    tick();
    bus.stall = 1'b0;
    outs("stall_rel", 32'h14, 1, 1, 0, 1, 0);
    tick();

    // Redirect beats stall, low bits masked
    bus.pc_cur          = 32'h14;
    bus.stall           = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h203;
    outs("redir_stall", 32'h200, 1, 1, 1, 0, 0);
    tick();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;

    // imem not ready for three cycles, redirects in the first two
    bus.pc_cur          = 32'h40;
    bus.imem_ready      = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h100;
    outs("wait_c1", 32'h44, 0, 1, 1, 0, 0);
    tick();
    bus.redirect_target = 32'h182;
    outs("wait_c2", 32'h44, 0, 1, 1, 0, 1);
    tick();
    bus.redirect_valid = 1'b0;
    outs("wait_c3", 32'h44, 0, 1, 0, 0, 1);
    tick();
    bus.imem_ready = 1'b1;
    outs("wait_rel", 32'h180, 1, 1, 1, 0, 1);
    tick();
    bus.pc_cur = 32'h180;
    outs("after_redir", 32'h184, 1, 1, 0, 1, 0);
    tick();

    // Plain wait then live redirect on release
    bus.pc_cur     = 32'h184;
    bus.imem_ready = 1'b0;
    outs("bp_run", 32'h188, 0, 1, 0, 0, 0);
    tick();
    bus.imem_ready      = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h57;
    outs("bp_live_redir", 32'h54, 1, 1, 1, 0, 0);
    tick();
    bus.redirect_valid = 1'b0;

    // Plain wait then sequential on release
    bus.pc_cur     = 32'h54;
    bus.imem_ready = 1'b0;
    outs("bp2_run", 32'h58, 0, 1, 0, 0, 0);
    tick();
    outs("bp2_wait", 32'h58, 0, 1, 0, 0, 0);
    bus.imem_ready = 1'b1;
    outs("bp2_rel", 32'h58, 1, 1, 0, 1, 0);
    tick();

    // Address wrap
    bus.pc_cur = 32'hFFFF_FFFC;
    outs("wrap", 32'h0, 1, 1, 0, 1, 0);
    tick();

    // Reset while a redirect is pending
    bus.pc_cur          = 32'h20;
    bus.imem_ready      = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h300;
    outs("rw_capture", 32'h24, 0, 1, 1, 0, 0);
    tick();
    bus.redirect_valid = 1'b0;
    outs("rw_pending", 32'h24, 0, 1, 0, 0, 1);
    rst = 1'b1;
    outs("rw_rst", 32'h0, 0, 0, 1, 0, 0);
    tick();
    rst            = 1'b0;
    bus.pc_cur     = 32'h0;
    bus.imem_ready = 1'b1;
    outs("rw_boot", 32'h4, 0, 0, 1, 0, 0);
    tick();
    outs("rw_restart", 32'h4, 1, 1, 0, 1, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_pc_controller.md
Name: fetch_pc_controller

Overview:
- Sequences the fetch-stage program counter register. Each cycle it computes the next-PC value and the PC write-enable, and issues the instruction-memory fetch request.
- Arbitrates between the branch/jump redirect from EX, the load-use stall from the hazard unit, and instruction-memory back-pressure. Generates the IF/ID flush.
- Drives the PC register's PC_in/PC_Write directly; reads back the PC register output.

Parameters:
RESET_VECTOR, 32'h0000_0000, boot address; must equal the PC register reset value
PC_STEP, 4, sequential increment in bytes
XLEN, 32, PC/address width

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
pc_cur  input  XLEN  current PC (PC register output)
stall  input  1  load-use stall from hazard unit; hold PC and IF/ID
redirect_valid  input  1  taken branch/jump resolved in EX this cycle
redirect_target  input  XLEN  redirect destination address
imem_ready  input  1  imem accepts request at pc_cur this cycle; instruction data valid same cycle
pc_next  output  XLEN  value for PC register PC_in
pc_write  output  1  PC register PC_Write
imem_req  output  1  fetch request at pc_cur
if_id_flush  output  1  insert bubble into IF/ID
fetch_valid  output  1  instruction at pc_cur is correct-path and enters IF/ID this cycle
redirect_pending  output  1  redirect captured, waiting for imem

Behaviour:
- Reset:
  - One clock; the reset is synchronous and active-high. Clock and reset ports are named clk and rst.
  - While rst=1: state=BOOT, pend_valid=0, pend_target=0.
  - Outputs during rst: pc_next=RESET_VECTOR, pc_write=0, imem_req=0, if_id_flush=1, fetch_valid=0, redirect_pending=0.
  - rst mid-operation discards any pending redirect.
- State registers: state {BOOT, RUN, WAIT}, pend_valid, pend_target[XLEN-1:0]. All other outputs are combinational from state, registers and inputs.
- Arithmetic:
  - seq_pc = pc_cur + PC_STEP, modulo 2^XLEN (0xFFFF_FFFC wraps to 0x0000_0000).
  - Redirect addresses have bits[1:0] forced to 0 before use or capture.
- Address-stability rule: once imem_req=1 and imem_ready=0, pc_write stays 0 until imem_ready=1, so pc_cur stays stable.
- BOOT:
  - Outputs: imem_req=0, pc_write=0, if_id_flush=1, fetch_valid=0.
  - Next state is always RUN. redirect_valid and stall are ignored.
- RUN (imem_req=1), highest priority first:
  1. redirect_valid=1:
     - if_id_flush=1, fetch_valid=0.
     - If imem_ready=1: pc_next=target, pc_write=1, stay in RUN.
     - Else: pc_write=0, capture pend_target=target, pend_valid=1, go to WAIT.
     - Redirect beats stall.
  2. stall=1:
     - pc_write=0, fetch_valid=0, if_id_flush=0, stay in RUN.
     - Data fetched this cycle is dropped and refetched from the same PC.
  3. imem_ready=0: pc_write=0, fetch_valid=0, go to WAIT.
  4. Otherwise: pc_next=seq_pc, pc_write=1, fetch_valid=1.
- WAIT (imem_req=1, pc_write=0 while imem_ready=0):
  - redirect_valid=1 with imem_ready=0:
    - Overwrite pend_target (last redirect wins), set pend_valid=1.
    - if_id_flush=1.
  - imem_ready=1 and (pend_valid=1 or redirect_valid=1):
    - pc_next = redirect_target if redirect_valid=1, else pend_target.
    - pc_write=1, if_id_flush=1, fetch_valid=0.
    - Clear pend_valid, go to RUN.
  - imem_ready=1, no redirect, stall=1: pc_write=0, fetch_valid=0, go to RUN.
  - imem_ready=1, no redirect, stall=0: pc_next=seq_pc, pc_write=1, fetch_valid=1, go to RUN.
- Other output rules:
  - redirect_pending = pend_valid.
  - pc_next = seq_pc whenever no other value is specified.
  - fetch_valid and if_id_flush are never both 1.
- Latency: the PC updates on the clock edge after pc_write=1. A redirect accepted with imem_ready=1 lands one cycle after redirect_valid.

Test Plan:
- Boot: rst held 3 cycles then released, imem_ready=1 -> one BOOT cycle (imem_req=0, flush=1); then pc_next sequence 0x4, 0x8, 0xC with pc_write=1 and fetch_valid=1.
- Stall: at pc_cur=0x10, stall=1 for 2 cycles -> pc_write=0, fetch_valid=0 for 2 cycles; pc_write=1 with pc_next=0x14 in the cycle stall drops.
- Redirect vs stall: stall=1 and redirect_valid=1 with target=0x203 in the same cycle -> pc_next=0x200, pc_write=1, if_id_flush=1.
- Wait plus redirect: imem_ready=0 for 3 cycles at pc_cur=0x40, redirect to 0x100 in cycle 1 and to 0x180 in cycle 2:
  - pc_write=0 throughout; redirect_pending=1.
  - On imem_ready=1: pc_next=0x180, pc_write=1, flush=1.
  - redirect_pending=0 next cycle.
- Wrap: pc_cur=0xFFFF_FFFC, imem_ready=1 -> pc_next=0x0000_0000.
- Reset mid-wait: pend_valid=1 in WAIT, assert rst for 1 cycle -> redirect_pending=0, next cycle is BOOT, then fetching restarts at RESET_VECTOR.
